video_mixer_ex: RTL and testbench

Parametrised final video output stage for core-side video, a successor to the fixed 4/8-bit mixer stage. It widens any colour depth to 8 bits and applies per-line scanline darkening. It generates edge-latched DE, optionally blacks out blanked pixels, and measures active resolution per frame. It sits after the scandoubler/gamma path and drives the VGA_* bus to the framework.

---
 rtl/video_pkg.sv | 21 ++
 rtl/video_res_meter.sv | 60 ++++++
 rtl/video_mixer_ex.sv | 133 +++++++++++++
 tb/tb_video_mixer_ex.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared scanline encodings and colour widening for the video output stage
package video_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_75  = 2'd1,
    SL_50  = 2'd2,
    SL_25  = 2'd3
  } sl_mode_e;

  // c holds a cw-bit colour in its low bits; its bits are repeated MSB-first to fill 8 bits
  function automatic logic [7:0] widen(input logic [7:0] c, input int cw);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[3'(7 - i)] = c[3'(cw - 1 - (i % cw))];
    end
    return w;
  endfunction

endpackage

// File: rtl/video_res_meter.sv
// rtl/video_res_meter.sv - active pixels per line and active lines per frame, saturating
module video_res_meter
  import video_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             en,
  input  logic             hde,
  input  logic             vde,
  input  logic             vs,
  output logic [CNT_W-1:0] hres,
  output logic [CNT_W-1:0] vres
);

  logic             hde_q;
  logic             vs_q;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             hde_fall;
  logic             vs_rise;
  logic             line_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign hde_fall = hde_q & ~hde;
  assign vs_rise  = vs & ~vs_q;
  assign line_end = hde_fall & vde;

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      hde_q    <= 1'b0;
      vs_q     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      hres     <= '0;
      vres     <= '0;
    end else if (en) begin
      hde_q <= hde;
      vs_q  <= vs;
      if (hde) begin
        pix_cnt <= sat_inc(pix_cnt);
      end else if (hde_fall) begin
        hres    <= pix_cnt;
        pix_cnt <= '0;
      end
      // a line ending on the same update as the VSync rise still belongs to the closing frame
      if (vs_rise) begin
        vres     <= line_end ? sat_inc(line_cnt) : line_cnt;
        line_cnt <= '0;
      end else if (line_end) begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

endmodule

// File: rtl/video_mixer_ex.sv
// rtl/video_mixer_ex.sv - final video output stage: widening, scanlines, DE, blanking, resolution
module video_mixer_ex
  import video_pkg::*;
#(
  parameter int CW          = 8,
  parameter int BLANK_BLACK = 1,
  parameter int HS_INV      = 0,
  parameter int VS_INV      = 0,
  parameter int CNT_W       = 12
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             ce_pix,
  input  logic [CW-1:0]    R,
  input  logic [CW-1:0]    G,
  input  logic [CW-1:0]    B,
  input  logic             HSync,
  input  logic             VSync,
  input  logic             HBlank,
  input  logic             VBlank,
  input  logic [1:0]       sl_mode,
  input  logic             sl_phase,
  output logic             CE_PIXEL,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_DE,
  output logic [CNT_W-1:0] HRES,
  output logic [CNT_W-1:0] VRES
);

  logic [7:0] a_r, a_g, a_b;
  logic       a_hde, a_vde, a_hs, a_vs;
  logic       b_hde, b_vs, parity;
  logic       hde_rise, vs_rise;
  logic       parity_nx, dim, de_nx, blank;
  logic [7:0] out_r, out_g, out_b;

  function automatic logic [7:0] shade(input logic [7:0] c, input logic [1:0] m);
    case (sl_mode_e'(m))
      SL_75:   return c - (c >> 2);
      SL_50:   return c >> 1;
      SL_25:   return c >> 2;
      default: return c;
    endcase
  endfunction

  assign hde_rise = a_hde & ~b_hde;
  assign vs_rise  = a_vs & ~b_vs;

  always_comb begin
    parity_nx = parity;
    if (vs_rise) begin
      parity_nx = 1'b0;
    end else if (hde_rise) begin
      parity_nx = ~parity;
    end
  end

  // the parity decision uses the post-update value so the first pixel of a line is already shaded
  assign dim   = (sl_mode_e'(sl_mode) != SL_OFF) && (parity_nx == sl_phase) && a_hde;
  assign de_nx = (a_hde != b_hde) ? (a_vde & a_hde) : VGA_DE;
  assign blank = (BLANK_BLACK != 0) && !de_nx;

  always_comb begin
    out_r = dim ? shade(a_r, sl_mode) : a_r;
    out_g = dim ? shade(a_g, sl_mode) : a_g;
    out_b = dim ? shade(a_b, sl_mode) : a_b;
    if (blank) begin
      out_r = '0;
      out_g = '0;
      out_b = '0;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      CE_PIXEL <= 1'b0;
      a_r      <= '0;
      a_g      <= '0;
      a_b      <= '0;
      a_hde    <= 1'b0;
      a_vde    <= 1'b0;
      a_hs     <= 1'b0;
      a_vs     <= 1'b0;
      b_hde    <= 1'b0;
      b_vs     <= 1'b0;
      parity   <= 1'b0;
      VGA_R    <= '0;
      VGA_G    <= '0;
      VGA_B    <= '0;
      VGA_HS   <= 1'b0;
      VGA_VS   <= 1'b0;
      VGA_DE   <= 1'b0;
    end else begin
      CE_PIXEL <= ce_pix;
      a_r      <= widen(8'(R), CW);
      a_g      <= widen(8'(G), CW);
      a_b      <= widen(8'(B), CW);
      a_hde    <= ~HBlank;
      a_vde    <= ~VBlank;
      a_hs     <= HSync;
      a_vs     <= VSync;
      if (CE_PIXEL) begin
        VGA_R  <= out_r;
        VGA_G  <= out_g;
        VGA_B  <= out_b;
        VGA_HS <= a_hs ^ (HS_INV != 0);
        VGA_VS <= a_vs ^ (VS_INV != 0);
        VGA_DE <= de_nx;
        b_hde  <= a_hde;
        b_vs   <= a_vs;
        parity <= parity_nx;
      end
    end
  end

  video_res_meter #(
    .CNT_W(CNT_W)
  ) u_res_meter (
    .CLK_VIDEO(CLK_VIDEO),
    .RESET_N  (RESET_N),
    .en       (CE_PIXEL),
    .hde      (a_hde),
    .vde      (a_vde),
    .vs       (a_vs),
    .hres     (HRES),
    .vres     (VRES)
  );

endmodule

// File: tb/tb_video_mixer_ex.sv
// tb/tb_video_mixer_ex.sv - scoreboard bench for video_mixer_ex (CW=4, inverted syncs, 12-bit counters)
`timescale 1ns/1ps
module tb_video_mixer_ex;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce_pix = 1'b0;
  logic [CW-1:0] r = '0, g = '0, b = '0;
  logic          hs = 1'b0, vs = 1'b0, hb = 1'b1, vb = 1'b1;
  logic [1:0]    sl_mode = 2'd0;
  logic          sl_phase = 1'b1;
  logic          CE_PIXEL, VGA_HS, VGA_VS, VGA_DE;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic [11:0]   HRES, VRES;

  logic [CW-1:0] cr = '0, cg = '0, cb = '0;

  typedef struct {
    int          tid;
    bit          m_rgb, m_de, m_sync, m_h, m_v;
    logic [23:0] rgb;
    bit          de;
    logic [1:0]  sync;
    int          hres, vres;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   gap = 1;
  bit   mon_en = 1'b0;
  bit   pend = 1'b0;

  video_mixer_ex #(
    .CW(CW), .BLANK_BLACK(1), .HS_INV(1), .VS_INV(1), .CNT_W(12)
  ) dut (
    .CLK_VIDEO(clk), .RESET_N(rst_n), .ce_pix(ce_pix),
    .R(r), .G(g), .B(b), .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb),
    .sl_mode(sl_mode), .sl_phase(sl_phase),
    .CE_PIXEL(CE_PIXEL), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .HRES(HRES), .VRES(VRES)
  );

  always #5 clk = ~clk;

  function automatic string tname(input int id);
    case (id)
      0: return "widen";
      1: return "frame240";
      2: return "hres320";
      3: return "sl50";
      4: return "sl75";
      5: return "sl25";
      6: return "vs_coincide";
      7: return "vblank_mid";
      8: return "hres_sat";
      9: return "post_reset";
      default: return "misc";
    endcase
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int tid, input logic [23:0] rgb, input bit de, input logic [1:0] sync);
    exp_t e;
    e.tid = tid;
    e.m_rgb = 1; e.m_de = 1; e.m_sync = 1; e.m_h = 0; e.m_v = 0;
    e.rgb = rgb; e.de = de; e.sync = sync; e.hres = 0; e.vres = 0;
    return e;
  endfunction

  // One stage-B update per issued pixel; checked at the falling edge after it lands.
  always @(negedge clk) begin
    if (mon_en && pend) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: output update with empty queue");
      end else begin
        mon_e = q.pop_front();
        if (mon_e.m_rgb)  cmp({tname(mon_e.tid), "_rgb"}, 64'({VGA_R, VGA_G, VGA_B}), 64'(mon_e.rgb));
        if (mon_e.m_de)   cmp({tname(mon_e.tid), "_de"}, 64'(VGA_DE), 64'(mon_e.de));
        if (mon_e.m_sync) cmp({tname(mon_e.tid), "_sync"}, 64'({VGA_HS, VGA_VS}), 64'(mon_e.sync));
        if (mon_e.m_h)    cmp({tname(mon_e.tid), "_hres"}, 64'(HRES), 64'(mon_e.hres));
        if (mon_e.m_v)    cmp({tname(mon_e.tid), "_vres"}, 64'(VRES), 64'(mon_e.vres));
      end
    end
    pend = mon_en && CE_PIXEL;
  end

  task automatic pix(input bit hb_i, input bit vb_i, input bit hs_i, input bit vs_i, input exp_t e);
    @(negedge clk);
    r = cr; g = cg; b = cb;
    hb = hb_i; vb = vb_i; hs = hs_i; vs = vs_i;
    ce_pix = 1'b1;
    q.push_back(e);
    repeat (gap - 1) begin
      @(negedge clk);
      ce_pix = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk);
      ce_pix = 1'b0;
    end
  endtask

  // w active pixels (VBlank from pixel vb_from on), then 4 blank pixels: VSync on 0-1, HSync on 2-3
  task automatic line(input int w, input int vb_from, input bit vs_f, input logic [23:0] act,
                      input int exp_v, input int tid);
    exp_t e;
    bit   de_act;
    bit   hsb, vsb;
    de_act = (vb_from != 0);
    for (int k = 0; k < w; k++) begin
      e = mk(tid, de_act ? act : 24'h0, de_act, 2'b11);
      pix(1'b0, k >= vb_from, 1'b0, 1'b0, e);
    end
    for (int k = 0; k < 4; k++) begin
      hsb = (k >= 2);
      vsb = vs_f && (k < 2);
      e = mk(tid, 24'h0, 1'b0, {~hsb, ~vsb});
      if (k == 0) begin
        e.m_h = 1;
        e.hres = (w > 4095) ? 4095 : w;
        if (exp_v >= 0) begin
          e.m_v = 1;
          e.vres = exp_v;
        end
      end
      pix(1'b1, vb_from < w, hsb, vsb, e);
    end
  endtask

  // VSync line (in VBlank), nact active lines alternating dark/bright, one trailing VBlank line
  task automatic frame(input int nact, input int w, input int exp_v,
                       input logic [7:0] dark, input logic [7:0] bright, input int tid);
    logic [7:0] c;
    line(w, 0, 1'b1, 24'h0, exp_v, tid);
    for (int i = 0; i < nact; i++) begin
      c = (i % 2 == 0) ? dark : bright;
      line(w, w, 1'b0, {c, c, c}, -1, tid);
    end
    line(w, 0, 1'b0, 24'h0, -1, tid);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t d;
    repeat (3) @(negedge clk);
    cmp("reset_vga", 64'({VGA_R, VGA_G, VGA_B, VGA_DE, VGA_HS, VGA_VS, CE_PIXEL}), 64'h0);
    cmp("reset_res", 64'({HRES, VRES}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;

    cr = 4'hA; cg = 4'h3; cb = 4'hF;
    gap = 4;
    line(4, 4, 1'b0, {8'hAA, 8'h33, 8'hFF}, -1, 0);
    drain();

    gap = 1;
    cr = 4'hF; cg = 4'hF; cb = 4'hF;
    frame(240, 8, 1, 8'hFF, 8'hFF, 1);
    frame(240, 8, 240, 8'hFF, 8'hFF, 1);
    frame(4, 320, 240, 8'hFF, 8'hFF, 2);
    drain();

    sl_mode = 2'd2; sl_phase = 1'b1;
    frame(4, 8, 4, 8'h7F, 8'hFF, 3);
    drain();
    sl_mode = 2'd1;
    frame(4, 8, 4, 8'hC0, 8'hFF, 4);
    drain();
    sl_mode = 2'd3;
    frame(4, 8, 4, 8'h3F, 8'hFF, 5);
    drain();
    sl_mode = 2'd0;

    line(8, 0, 1'b1, 24'h0, 4, 6);
    line(8, 8, 1'b0, 24'hFFFFFF, -1, 6);
    line(8, 8, 1'b0, 24'hFFFFFF, -1, 6);
    line(8, 8, 1'b1, 24'hFFFFFF, 3, 6);

    line(8, 4, 1'b0, 24'hFFFFFF, -1, 7);
    line(8, 0, 1'b0, 24'h0, -1, 7);

    line(4100, 4100, 1'b0, 24'hFFFFFF, -1, 8);
    drain();

    @(posedge clk); #1 mon_en = 1'b0;
    gap = 2;
    d = mk(10, 24'h0, 1'b0, 2'b00);
    d.m_rgb = 0; d.m_de = 0; d.m_sync = 0;
    for (int k = 0; k < 3; k++) pix(1'b0, 1'b0, 1'b0, 1'b0, d);
    ce_pix = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset_vga", 64'({VGA_R, VGA_G, VGA_B, VGA_DE, VGA_HS, VGA_VS, CE_PIXEL}), 64'h0);
    cmp("async_reset_res", 64'({HRES, VRES}), 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ce_pix = ~ce_pix;
    end
    #1;
    cmp("held_reset_vga", 64'({VGA_R, VGA_G, VGA_B, VGA_DE, VGA_HS, VGA_VS, CE_PIXEL}), 64'h0);
    @(negedge clk);
    ce_pix = 1'b0;
    hb = 1'b1;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1 mon_en = 1'b1;
    gap = 1;
    line(10, 10, 1'b0, 24'hFFFFFF, -1, 9);
    drain();

    cmp("sb_drain", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
